seven_seg_scan_driver: RTL and testbench

Parametrised multi-digit 7-segment display driver. It converts a binary value to BCD with a sequential double-dabble engine (one shift per clock) and stores the result in display registers. It then time-multiplexes the digits onto a shared active-low segment bus with one-hot active-low digit enables. It sits between datapath result registers (e.g. ALU output) and the board display pins.

---
 rtl/seven_seg_scan_driver_if.sv | 44 ++++
 rtl/seven_seg_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if
//   Bundles the request side and the display-pin side of the 7-segment
//   scan driver. The clock and reset stay plain module ports.
//
// Handshake: load is a request that the driver samples only while it is
// idle (busy=0). A load seen while busy=1 is dropped, never queued. Each
// accepted request ends with a single-cycle done pulse. busy falls on the
// same edge, and the new digits are committed on that edge too. There is
// no ready signal. busy=0 is the only indication that a load will be taken.
//
// Signals
//   load      master->slave  convert num_bin (sampled in IDLE only)
//   num_bin   master->slave  unsigned binary value
//   blank_lz  master->slave  blank leading zeros, sampled with load
//   busy      slave->master  conversion in progress
//   done      slave->master  one-cycle pulse, new digits committed
//   overflow  slave->master  last committed value did not fit the digits
//   display   slave->master  active-low one-hot digit enables
//   segments  slave->master  {dp,g,f,e,d,c,b,a}, active-low
//   state     slave->master  FSM state, for debug and checkers
interface seven_seg_scan_driver_if #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 4
);
  logic                 load;
  logic [BIN_WIDTH-1:0] num_bin;
  logic                 blank_lz;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [DIGITS-1:0]    display;
  logic [7:0]           segments;
  logic [1:0]           state;

  modport master (
    output load, num_bin, blank_lz,
    input  busy, done, overflow, display, segments, state
  );

  modport slave (
    input  load, num_bin, blank_lz,
    output busy, done, overflow, display, segments, state
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Converts a binary value to BCD using a sequential double-dabble engine,
//   which does one shift per clock. On completion it commits the digits to
//   display registers. Those digits are time-multiplexed onto a shared
//   active-low segment bus. The bus uses active-low one-hot digit enables.
//
// Ports
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   bus    seven_seg_scan_driver_if.slave (load/num_bin/blank_lz in;
//          busy/done/overflow/display/segments/state out)
module seven_seg_scan_driver #(
  parameter int BIN_WIDTH   = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  seven_seg_scan_driver_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int RD_W  = $clog2(REFRESH_DIV);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // The comparison width must hold 10^8-1 (27 bits) as well as num_bin.
  localparam int CW    = (BIN_WIDTH > 27) ? BIN_WIDTH : 27;
  localparam logic [CW-1:0] MAX_VAL = CW'(10 ** DIGITS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]       state_q;
  logic             busy_q, done_q, overflow_q, ovf_pend_q;
  logic             blz_pend_q, blz_q;
  logic [SR_W-1:0]  shift_q, adj, shifted;
  logic [CNT_W-1:0] iter_q;
  logic [3:0]       digit_q [DIGITS];
  logic [CW-1:0]    num_ext;

  logic [RD_W-1:0]   refresh_q;
  logic [IW-1:0]     index_q;
  logic [DIGITS-1:0] display_q;
  logic [7:0]        segments_q, seg_next;
  logic [3:0]        sel_digit;
  logic              sel_blank, zero_above;

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'd0: decode = 8'hC0;
      4'd1: decode = 8'hF9;
      4'd2: decode = 8'hA4;
      4'd3: decode = 8'hB0;
      4'd4: decode = 8'h99;
      4'd5: decode = 8'h92;
      4'd6: decode = 8'h82;
      4'd7: decode = 8'hF8;
      4'd8: decode = 8'h80;
      4'd9: decode = 8'h90;
      default: decode = 8'hFF;
    endcase
  endfunction

  always_comb num_ext = CW'(bus.num_bin);

  // Double-dabble step: correct every BCD nibble >=5 and then shift the
  // whole register left by one.
  always_comb begin
    adj = shift_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[BIN_WIDTH + 4*i +: 4] >= 4'd5)
        adj[BIN_WIDTH + 4*i +: 4] = adj[BIN_WIDTH + 4*i +: 4] + 4'd3;
    end
    shifted = {adj[SR_W-2:0], 1'b0};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      blz_pend_q <= 1'b0;
      blz_q      <= 1'b0;
      shift_q    <= '0;
      iter_q     <= '0;
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.load) begin
            shift_q    <= SR_W'(bus.num_bin);
            blz_pend_q <= bus.blank_lz;
            ovf_pend_q <= (num_ext > MAX_VAL);
            iter_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          shift_q <= shifted;
          iter_q  <= iter_q + 1'b1;
          if (iter_q == CNT_W'(BIN_WIDTH - 1)) state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          // Blanking mode is committed together with the digits, so the
          // digits that are still displayed never change appearance mid-conversion.
          for (int i = 0; i < DIGITS; i++)
            digit_q[i] <= shift_q[BIN_WIDTH + 4*i +: 4];
          overflow_q <= ovf_pend_q;
          blz_q      <= blz_pend_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Select the digit that is currently scanned. A digit above 0 is blank
  // when it is zero and so is every digit above it.
  always_comb begin
    sel_digit  = 4'd0;
    sel_blank  = 1'b0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (digit_q[i] == 4'd0);
      if (IW'(i) == index_q) begin
        sel_digit = digit_q[i];
        sel_blank = blz_q && zero_above && (i != 0);
      end
    end
    if (overflow_q)     seg_next = 8'hBF;
    else if (sel_blank) seg_next = 8'hFF;
    else                seg_next = decode(sel_digit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_q  <= '0;
      index_q    <= '0;
      display_q  <= '1;
      segments_q <= 8'hFF;
    end else begin
      if (refresh_q == RD_W'(REFRESH_DIV - 1)) begin
        refresh_q <= '0;
        index_q   <= (index_q == IW'(DIGITS - 1)) ? '0 : index_q + 1'b1;
      end else begin
        refresh_q <= refresh_q + 1'b1;
      end
      display_q  <= ~(DIGITS'(1) << index_q);
      segments_q <= seg_next;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.display  = display_q;
  assign bus.segments = segments_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;
  localparam int RD = 4;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  seven_seg_scan_driver_if #(.BIN_WIDTH(8), .DIGITS(4)) bus  ();
  seven_seg_scan_driver_if #(.BIN_WIDTH(8), .DIGITS(2)) bus2 ();

  seven_seg_scan_driver #(.BIN_WIDTH(8), .DIGITS(4), .REFRESH_DIV(RD)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  seven_seg_scan_driver #(.BIN_WIDTH(8), .DIGITS(2), .REFRESH_DIV(RD)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic do_load(input bit which, input logic [7:0] v, input bit blz);
    @(negedge clock);
    if (which) begin bus2.load = 1'b1; bus2.num_bin = v; bus2.blank_lz = blz; end
    else       begin bus.load  = 1'b1; bus.num_bin  = v; bus.blank_lz  = blz; end
    @(posedge clock);
    @(negedge clock);
    bus.load  = 1'b0;
    bus2.load = 1'b0;
  endtask

  task automatic wait_done(input bit which, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      if ((which ? bus2.done : bus.done) === 1'b1) ok = 1'b1;
      else @(negedge clock);
    end
  endtask

  // Wait for digit d to be enabled, then return its segments.
  task automatic get_seg(input bit which, input int d, output logic [7:0] seg, output bit ok);
    logic [3:0] want4;
    logic [1:0] want2;
    want4 = ~(4'b0001 << d);
    want2 = ~(2'b01 << d);
    ok  = 1'b0;
    seg = 8'hxx;
    @(posedge clock);
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clock);
      if (which ? (bus2.display === want2) : (bus.display === want4)) begin
        ok  = 1'b1;
        seg = which ? bus2.segments : bus.segments;
      end
    end
  endtask

  task automatic check_digits(input string name, input bit which, input int n,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_seg [4];
    logic [7:0] seg;
    bit ok;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    for (int d = 0; d < n; d++) begin
      get_seg(which, d, seg, ok);
      tests++;
      if (!ok || seg !== exp_seg[d]) begin
        fails++;
        $display("FAIL %s digit%0d: got %h (enable seen=%0d) want %h", name, d, seg, ok, exp_seg[d]);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.display !== 4'b1111 || bus.segments !== 8'hFF) begin
      fails++;
      $display("FAIL reset_hold: busy=%b done=%b ovf=%b disp=%b seg=%h want 0 0 0 1111 FF",
               bus.busy, bus.done, bus.overflow, bus.display, bus.segments);
    end
    reset = 1'b0;
    // Abort a conversion with a mid-cycle asynchronous reset.
    do_load(1'b0, 8'd255, 1'b0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.display !== 4'b1111 || bus.segments !== 8'hFF) begin
      fails++;
      $display("FAIL reset_async: busy=%b done=%b disp=%b seg=%h want 0 0 1111 FF",
               bus.busy, bus.done, bus.display, bus.segments);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (RD) @(posedge clock);
    #1;
    tests++;
    if (bus.display !== 4'b1110 || bus.segments !== 8'hC0) begin
      fails++;
      $display("FAIL reset_release: disp=%b seg=%h want 1110 C0", bus.display, bus.segments);
    end
  endtask

  task automatic test_latency();
    @(negedge clock);
    bus.load = 1'b1; bus.num_bin = 8'd255; bus.blank_lz = 1'b0;
    @(posedge clock);
    #1;
    tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL lat_edge_k: busy=%b done=%b want 1 0", bus.busy, bus.done);
    end
    @(negedge clock);
    bus.load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock);
      #1;
      tests++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        fails++;
        $display("FAIL lat_k+%0d: busy=%b done=%b want 1 0", c, bus.busy, bus.done);
      end
    end
    @(posedge clock);
    #1;
    tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL lat_k+9: done=%b busy=%b want 1 0", bus.done, bus.busy);
    end
    @(posedge clock);
    #1;
    tests++;
    if (bus.done !== 1'b0) begin
      fails++;
      $display("FAIL lat_done_width: done=%b want 0", bus.done);
    end
    check_digits("lat_255", 1'b0, 4, 8'h92, 8'h92, 8'hA4, 8'hC0);
  endtask

  task automatic test_scan();
    logic [3:0] exp_disp [5];
    bit ok;
    exp_disp[0] = 4'b1110; exp_disp[1] = 4'b1101; exp_disp[2] = 4'b1011;
    exp_disp[3] = 4'b0111; exp_disp[4] = 4'b1110;
    // Synchronise to the start of a 1110 period.
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clock);
      if (bus.display === 4'b0111) ok = 1'b1;
    end
    for (int c = 0; c < 10 && ok && bus.display === 4'b0111; c++) @(negedge clock);
    tests++;
    if (!ok || bus.display !== 4'b1110) begin
      fails++;
      $display("FAIL scan_sync: disp=%b want 1110 after 0111", bus.display);
    end
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < RD; c++) begin
        tests++;
        if (bus.display !== exp_disp[k]) begin
          fails++;
          $display("FAIL scan_step%0d_cyc%0d: disp=%b want %b", k, c, bus.display, exp_disp[k]);
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic test_blanking();
    bit ok;
    do_load(1'b0, 8'd7, 1'b1);
    wait_done(1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL blank7_done: got no done want done"); end
    check_digits("blank_7", 1'b0, 4, 8'hF8, 8'hFF, 8'hFF, 8'hFF);
    do_load(1'b0, 8'd0, 1'b1);
    wait_done(1'b0, ok);
    check_digits("blank_0", 1'b0, 4, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    do_load(1'b0, 8'd0, 1'b0);
    wait_done(1'b0, ok);
    check_digits("noblank_0", 1'b0, 4, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
  endtask

  task automatic test_overflow();
    bit ok;
    do_load(1'b1, 8'd100, 1'b0);
    wait_done(1'b1, ok);
    tests++;
    if (!ok || bus2.overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_100: done_seen=%0d overflow=%b want 1 1", ok, bus2.overflow);
    end
    check_digits("ovf_100", 1'b1, 2, 8'hBF, 8'hBF, 8'hFF, 8'hFF);
    do_load(1'b1, 8'd99, 1'b0);
    wait_done(1'b1, ok);
    tests++;
    if (!ok || bus2.overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_99: done_seen=%0d overflow=%b want 1 0", ok, bus2.overflow);
    end
    check_digits("ovf_99", 1'b1, 2, 8'h90, 8'h90, 8'hFF, 8'hFF);
  endtask

  task automatic test_busy_ignore();
    int done_cnt;
    int done_edge;
    done_cnt  = 0;
    done_edge = -1;
    @(negedge clock);
    bus.load = 1'b1; bus.num_bin = 8'd42; bus.blank_lz = 1'b0;
    @(posedge clock);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      bus.load    = (c == 3);
      bus.num_bin = (c == 3) ? 8'd13 : 8'd42;
      @(posedge clock);
      #1;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = c;
      end
    end
    @(negedge clock);
    bus.load = 1'b0;
    tests++;
    if (done_cnt != 1 || done_edge != 9) begin
      fails++;
      $display("FAIL busy_ignore: dones=%0d first_at=k+%0d want 1 at k+9", done_cnt, done_edge);
    end
    check_digits("busy_42", 1'b0, 4, 8'hA4, 8'h99, 8'hC0, 8'hC0);
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    first  = -1;
    second = -1;
    @(negedge clock);
    bus.load = 1'b1; bus.num_bin = 8'd3; bus.blank_lz = 1'b1;
    for (int c = 0; c < 40 && second < 0; c++) begin
      @(posedge clock);
      #1;
      if (bus.done === 1'b1) begin
        if (first < 0) first = c;
        else second = c;
      end
    end
    @(negedge clock);
    bus.load = 1'b0;
    tests++;
    if (first < 0 || second - first != 10) begin
      fails++;
      $display("FAIL back_to_back: done period=%0d want 10", second - first);
    end
    for (int c = 0; c < 20 && bus.busy !== 1'b0; c++) @(negedge clock);
    check_digits("b2b_3", 1'b0, 4, 8'hB0, 8'hFF, 8'hFF, 8'hFF);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.load  = 1'b0; bus.num_bin  = '0; bus.blank_lz  = 1'b0;
    bus2.load = 1'b0; bus2.num_bin = '0; bus2.blank_lz = 1'b0;
    test_reset();
    test_latency();
    test_scan();
    test_blanking();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
